// File: rtl/vga_layers_pkg.sv
// Shared types and constants for the VGA layer compositing path.
package vga_layers_pkg;

  localparam int unsigned NUM_LAYERS_DEFAULT = 4;
  localparam logic [7:0]  TRANSPARENT_COLOR  = 8'hFF;

  typedef logic [7:0] rgb332_t;
  typedef logic [$clog2(NUM_LAYERS_DEFAULT+1)-1:0] layer_idx_t;

  typedef enum logic {
    COLL_IDLE,
    COLL_HIT
  } coll_state_t;

endpackage

// File: rtl/collision_frame_tracker.sv
// Per-frame collision tracker: one-shot pulse on the first hit of a frame and
// a saturating hit count that is published at each frame boundary.
module collision_frame_tracker
  import vga_layers_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       hit,
  output logic       collisionPulse,
  output logic [7:0] frameCollisions
);

  coll_state_t state, state_d;
  logic [7:0]  run_cnt, run_cnt_d;
  logic [7:0]  frame_d;
  logic        pulse_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= COLL_IDLE;
      run_cnt         <= '0;
      frameCollisions <= '0;
      collisionPulse  <= 1'b0;
    end else begin
      state           <= state_d;
      run_cnt         <= run_cnt_d;
      frameCollisions <= frame_d;
      collisionPulse  <= pulse_d;
    end
  end

  // A hit coinciding with startOfFrame is counted in the new frame.
  always_comb begin
    state_d   = state;
    run_cnt_d = run_cnt;
    frame_d   = frameCollisions;
    pulse_d   = 1'b0;
    if (startOfFrame) begin
      frame_d   = run_cnt;
      run_cnt_d = hit ? 8'd1 : 8'd0;
      pulse_d   = hit;
      state_d   = hit ? COLL_HIT : COLL_IDLE;
    end else begin
      if (hit && run_cnt != '1) run_cnt_d = run_cnt + 8'd1;
      case (state)
        COLL_IDLE: if (hit) begin
          pulse_d = 1'b1;
          state_d = COLL_HIT;
        end
        COLL_HIT:  state_d = COLL_HIT;
        default:   state_d = COLL_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/layer_priority_arbiter.sv
// Per-pixel priority arbiter between drawing layers and the background, with
// frame-synchronous layer enables and layer-0 collision reporting.
module layer_priority_arbiter
  import vga_layers_pkg::*;
#(
  parameter int unsigned NUM_LAYERS        = NUM_LAYERS_DEFAULT,
  parameter rgb332_t     TRANSPARENT_COLOR = vga_layers_pkg::TRANSPARENT_COLOR
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              startOfFrame,
  input  logic [NUM_LAYERS-1:0]             layerDrawReq,
  input  logic [NUM_LAYERS-1:0][7:0]        layerRGB,
  input  logic [7:0]                        BG_RGB,
  input  logic                              boardersDrawReq,
  input  logic                              cfgWrEn,
  input  logic [NUM_LAYERS-1:0]             cfgLayerEn,
  output logic [7:0]                        RGBout,
  output logic [$clog2(NUM_LAYERS+1)-1:0]   activeLayer,
  output logic                              collisionPulse,
  output logic [7:0]                        frameCollisions
);

  localparam int unsigned IDX_W = $clog2(NUM_LAYERS+1);

  logic [NUM_LAYERS-1:0] pendingEn, activeEn;
  logic [NUM_LAYERS-1:0] eff;
  logic                  found;
  logic [IDX_W-1:0]      win_idx;
  rgb332_t               win_rgb;
  logic                  hit;

  // Shadow enable: a write coinciding with startOfFrame bypasses pendingEn.
  always_ff @(posedge clk) begin
    if (reset) begin
      pendingEn <= '1;
      activeEn  <= '1;
    end else begin
      if (cfgWrEn)      pendingEn <= cfgLayerEn;
      if (startOfFrame) activeEn  <= cfgWrEn ? cfgLayerEn : pendingEn;
    end
  end

  always_comb begin
    eff     = '0;
    found   = 1'b0;
    win_idx = IDX_W'(NUM_LAYERS);
    win_rgb = BG_RGB;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      eff[i] = layerDrawReq[i] & activeEn[i] & (layerRGB[i] != TRANSPARENT_COLOR);
      if (eff[i] && !found) begin
        found   = 1'b1;
        win_idx = IDX_W'(i);
        win_rgb = layerRGB[i];
      end
    end
  end

  assign hit = eff[0] & ((|eff[NUM_LAYERS-1:1]) | boardersDrawReq);

  always_ff @(posedge clk) begin
    if (reset) begin
      RGBout      <= '0;
      activeLayer <= IDX_W'(NUM_LAYERS);
    end else begin
      RGBout      <= win_rgb;
      activeLayer <= win_idx;
    end
  end

  collision_frame_tracker u_collision_frame_tracker (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .hit             (hit),
    .collisionPulse  (collisionPulse),
    .frameCollisions (frameCollisions)
  );

endmodule
